// File: rtl/imem_loader_pkg.sv
// Shared state encodings, PC-update select codes and length check for the IMem boot loader.
package imem_loader_pkg;

  localparam int IMEM_SIZE_DEF = 64;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CLR   = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_WRITE = 3'd3;
  localparam state_t S_STEP  = 3'd4;
  localparam state_t S_FIN   = 3'd5;
  localparam state_t S_RUN   = 3'd6;

  localparam logic [1:0] BOUT_HOLD = 2'b00;
  localparam logic [1:0] BOUT_STEP = 2'b01;

  // A load must move at least one word and must fit in the instruction memory.
  function automatic logic len_legal(input logic [31:0] len, input logic [31:0] size);
    return (len != 32'd0) && (len <= size);
  endfunction

endpackage

// File: rtl/imem_loader_cnt.sv
// Word counter for the boot loader: clear, increment, and a flag that is high when the
// next increment reaches the programmed load length.
module imem_loader_cnt #(
  parameter int CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = ((cnt_q + CNT_W'(1)) == len_i);

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader that owns the fetch stage's IMem write port and PC path while an image
// streams in, then releases the core. Define IMEM_LOADER_VERIFY_EN to read back each word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_SIZE = IMEM_SIZE_DEF,
  parameter int CNT_W     = $clog2(IMEM_SIZE) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [CNT_W-1:0] load_len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  input  logic [1:0]       core_bout,
  input  logic [31:0]      core_newpc,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_ins,
  output logic             if_rst,
  output logic             if_we,
  output logic [31:0]      if_w_ins,
  output logic [1:0]       if_bout,
  output logic [31:0]      if_newpc,
  output logic             cpu_run,
  output logic             busy,
  output logic             done,
  output logic             err,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             done_q;
  logic             cnt_clr, cnt_inc, cnt_last;
  logic             start_ok;
  logic             step_ok;

`ifdef IMEM_LOADER_VERIFY_EN
  // In STEP the fetch stage presents the word just written at the unchanged PC.
  assign step_ok = (if_ins == word_q);
`else
  logic unused_if_ins;
  assign unused_if_ins = ^if_ins;
  assign step_ok       = 1'b1;
`endif

  assign start_ok = len_legal(32'(load_len), 32'(IMEM_SIZE));

  imem_loader_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .len_i  (len_q),
    .last_o (cnt_last)
  );

  // Image handshake: a word moves on a cycle where in_valid and in_ready are both high;
  // in_ready is high only in WAIT, so in_valid at any other time moves nothing.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pc4_d   = pc4_q;
    len_d   = len_q;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          if (start_ok) begin
            state_d = S_CLR;
            len_d   = load_len;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLR: begin
        cnt_clr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (in_valid) begin
          word_d  = in_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // PC is held during the write, so its successor can be registered here.
        pc4_d   = if_pc + 32'd4;
        state_d = S_STEP;
      end
      S_STEP: begin
        if (!step_ok) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_inc = 1'b1;
          state_d = cnt_last ? S_FIN : S_WAIT;
        end
      end
      S_FIN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      pc4_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pc4_q   <= pc4_d;
      len_q   <= len_d;
      err_q   <= err_d;
      done_q  <= (state_q == S_FIN);
    end
  end

  assign dbg_state = state_q;
  assign in_ready  = (state_q == S_WAIT);
  assign if_we     = (state_q == S_WRITE);
  assign if_w_ins  = word_q;
  assign if_rst    = (state_q == S_IDLE) || (state_q == S_CLR) || (state_q == S_FIN);
  assign cpu_run   = (state_q == S_RUN);
  assign busy      = (state_q == S_CLR) || (state_q == S_WAIT) || (state_q == S_WRITE) ||
                     (state_q == S_STEP) || (state_q == S_FIN);
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    if_bout  = BOUT_HOLD;
    if_newpc = 32'd0;
    if (state_q == S_RUN) begin
      if_bout  = core_bout;
      if_newpc = core_newpc;
    end else if ((state_q == S_STEP) && step_ok) begin
      if_bout  = BOUT_STEP;
      if_newpc = pc4_q;
    end
  end

endmodule
